fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch stage feeding the control unit. Holds the fetch PC and issues word reads to the instruction cache. Buffers returned words in a small FIFO so decode back-pressure never drops a fetched instruction. Presents the oldest word (and its PC) on `instr` for the control unit and the IF/ID latch. Handles branch/jump redirects and processor halt.

## Interface
Parameters:
- `PC_INIT`, default 32'h0000_0000, PC fetched first after reset.
- `BUF_DEPTH`, default 2, FIFO entries; legal values 2 or 4.

Ports (reset is synchronous and active-high):
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous active-high reset.
- `ihit`  in  1  icache has valid data for `imemaddr` this cycle.
- `imemload`  in  32  instruction word from icache; valid when `ihit`.
- `imemREN`  out  1  read request to icache.
- `imemaddr`  out  32  word address of the request (`word_t`).
- `redirect`  in  1  taken branch/jump from execute; flush and refetch.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored, treated as 00.
- `halt`  in  1  halt retired; stop fetching permanently until reset.
- `instr`  out  32  oldest buffered instruction, to control unit `instr`.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` are meaningful.
- `instr_ready`  in  1  decode accepts the head entry this cycle.
- `count`  out  3  current FIFO occupancy, 0..BUF_DEPTH.

## Operation
- State: fetch PC register `fpc`, FIFO of {pc, instr} pairs with head/tail pointers and `count`, and a 2-state FSM.
- FSM states: FETCH (reset state) and HALTED.
  - FETCH → HALTED when `halt`=1.
  - HALTED is left only by `RST`.
- `imemaddr` = `fpc` at all times.
- `imemREN` = (state==FETCH) && (count < BUF_DEPTH) && !RST. It is registered-state only, with no combinational path from `instr_ready`, `redirect` or `ihit`.
- Push: when `imemREN && ihit && !redirect && !halt`, write {fpc, imemload} at tail and set fpc ← fpc + 4. The add wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Pop: when `instr_valid && instr_ready && !redirect && !halt`, advance head.
- Push and pop in the same cycle leave `count` unchanged. Both pointers advance. A full FIFO accepts no push, because `imemREN` is 0.
- `instr_valid` = (count != 0) && (state==FETCH).
- `instr`/`instr_pc` = head entry when valid, otherwise 32'h0.
- Redirect (state FETCH): flush FIFO (count ← 0, pointers ← 0), fpc ← {redirect_pc[31:2], 2'b00}. Any `imemload` returned that cycle is discarded and any pop that cycle is ignored.
- Halt: FIFO flushed, fpc frozen, `imemREN`=0, `instr_valid`=0. `redirect` is ignored while HALTED.
- Priority: RST > halt > redirect > push/pop.
- Reset (RST high at a rising edge):
  - fpc ← PC_INIT, FIFO empty, state FETCH.
  - `imemREN`=0 and `instr_valid`=0 while RST is high.
  - RST asserted mid-miss drops the request; there is no pending-request state to clear.

## Timing
- Icache hit latency is absorbed. `imemREN` stays high and `imemaddr` stays stable until `ihit`. Miss cycles change nothing.
- A word with `ihit` at edge t appears on `instr` with `instr_valid`=1 after edge t if the FIFO was empty. Fetch-to-decode latency is 1 cycle.
- Streaming hits with `instr_ready`=1 give one instruction per cycle. Steady-state `count` is 1.
- With `instr_ready`=0, fetching continues until count = BUF_DEPTH, then `imemREN` drops. It re-asserts the cycle after the first pop.
- `redirect` at edge t: from t+1, `imemaddr`=target and `instr_valid`=0. The first target instruction is valid the cycle after its `ihit`.
- `halt` at edge t: `imemREN`=0 and `instr_valid`=0 from t+1 onward.

## Test plan
- Reset with PC_INIT=0x200, `ihit`=1 every cycle, `imemload`=PC-derived, `instr_ready`=1 → `instr_pc` sequence 0x200, 0x204, 0x208 on consecutive cycles. `imemREN`=0 while RST=1.
- `instr_ready`=0 with continuous hits, BUF_DEPTH=2 → count goes 1, 2. `imemREN` falls with `imemaddr` held at 0x208. Raise ready → head 0x200 pops, then 0x204. `imemREN` rises the cycle after the first pop and no word is lost or duplicated.
- `ihit` held 0 for 5 cycles → `imemaddr` and `count` unchanged throughout. The word returned on the 6th cycle is the next `instr`.
- Redirect to 0x1003 while count=2 and `ihit`=1 that cycle → count 0 next cycle, `imemaddr`=0x1000, the hit word is discarded, and the next valid `instr_pc`=0x1000.
- PC wrap: redirect to 0xFFFFFFFC with hits → `instr_pc` sequence 0xFFFFFFFC, 0x00000000.
- `halt` asserted with count=1, then `redirect` pulsed → `instr_valid`=0 and `imemREN`=0 permanently. A later RST restarts fetch from PC_INIT.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: drives icache reads from the fetch PC and queues returned
// words with their PCs in a small FIFO, presenting the oldest entry to decode.
module fetch_buffer #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [2:0]  count
);

  typedef logic [31:0] word_t;
  typedef enum logic {FETCH, HALTED} state_t;

  localparam int         PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);

  state_t           state, next_state;
  word_t            fpc;
  word_t            buf_pc    [BUF_DEPTH];
  word_t            buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             push, pop, flush;

  // NOTE: every combinational output gets its default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (state == FETCH && halt) next_state = HALTED;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= next_state;
  end

  // Request and valid depend only on registered state (and reset), never on ready/redirect/ihit.
  assign imemaddr    = fpc;
  assign imemREN     = (state == FETCH) && (count < DEPTH_C) && !RST;
  assign instr_valid = (count != 3'd0) && (state == FETCH) && !RST;
  assign instr       = instr_valid ? buf_instr[head] : 32'h0;
  assign instr_pc    = instr_valid ? buf_pc[head]    : 32'h0;

  assign push  = imemREN && ihit && !redirect && !halt;
  assign pop   = instr_valid && instr_ready && !redirect && !halt;
  assign flush = (state == FETCH) && (halt || redirect);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc   <= PC_INIT;
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
      // Halt freezes the fetch PC; only a redirect in FETCH retargets it.
      if (!halt) fpc <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
        fpc  <= fpc + 32'd4;
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage is not reset; count gates every read, so stale contents are never seen.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_pc[tail]    <= fpc;
      buf_instr[tail] <= imemload;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based reference model.
module tb_fetch_buffer;

  localparam logic [31:0] PC_INIT = 32'h0000_0200;
  localparam int          D       = 2;

  logic        CLK = 1'b0;
  logic        RST, ihit, redirect, halt, instr_ready;
  logic [31:0] imemload, redirect_pc, imemaddr, instr, instr_pc;
  logic        imemREN, instr_valid;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_buffer #(.PC_INIT(PC_INIT), .BUF_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .count(count)
  );

  always #5 CLK = ~CLK;

  // Icache stand-in: the word returned for an address is a fixed function of that address.
  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {~pc[15:0], pc[31:16] ^ 16'h3C3C};
  endfunction

  assign imemload = ihit ? word_of(imemaddr) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; redirect = 1'b0; halt = 1'b0;
    instr_ready = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; ihit = 1'b1; instr_ready = 1'b1; redirect = 1'b0; halt = 1'b0;
    redirect_pc = 32'h0;
    tick();
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL reset_ren got=%b exp=0", imemREN); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    RST = 1'b0;
    #1;
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren_release got=%b exp=1", imemREN); end
    checks++; if (imemaddr !== PC_INIT) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imemaddr, PC_INIT); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = PC_INIT + 32'(4 * i);
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, instr_valid); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, exp_pc); end
      checks++; if (instr !== word_of(exp_pc)) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr, word_of(exp_pc)); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0; ihit = 1'b1;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_count1 got=%0d exp=1", count); end
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL bp_count2 got=%0d exp=2", count); end
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL bp_ren_full got=%b exp=0", imemREN); end
    checks++; if (imemaddr !== 32'h208) begin errors++; $display("FAIL bp_addr_full got=%h exp=00000208", imemaddr); end
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL bp_count_hold got=%0d exp=2", count); end
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL bp_head_hold got=%h exp=00000200", instr_pc); end
    instr_ready = 1'b1;
    #1;
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL bp_ren_no_comb got=%b exp=0", imemREN); end
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_pop_count got=%0d exp=1", count); end
    checks++; if (instr_pc !== 32'h204) begin errors++; $display("FAIL bp_pop_head got=%h exp=00000204", instr_pc); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL bp_ren_rise got=%b exp=1", imemREN); end
    tick();
    checks++; if (instr_pc !== 32'h208) begin errors++; $display("FAIL bp_next_head got=%h exp=00000208", instr_pc); end
    checks++; if (instr !== word_of(32'h208)) begin errors++; $display("FAIL bp_next_instr got=%h exp=%h", instr, word_of(32'h208)); end
    tick();
    checks++; if (instr_pc !== 32'h20C) begin errors++; $display("FAIL bp_after got=%h exp=0000020c", instr_pc); end
  endtask

  task automatic test_miss();
    do_reset();
    instr_ready = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (imemaddr !== PC_INIT) begin errors++; $display("FAIL miss_addr[%0d] got=%h exp=%h", i, imemaddr, PC_INIT); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL miss_count[%0d] got=%0d exp=0", i, count); end
      checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL miss_ren[%0d] got=%b exp=1", i, imemREN); end
    end
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL miss_hit_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_pc !== PC_INIT) begin errors++; $display("FAIL miss_hit_pc got=%h exp=%h", instr_pc, PC_INIT); end
    checks++; if (instr !== word_of(PC_INIT)) begin errors++; $display("FAIL miss_hit_instr got=%h exp=%h", instr, word_of(PC_INIT)); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL miss_drain got=%0d exp=0", count); end
    checks++; if (imemaddr !== 32'h204) begin errors++; $display("FAIL miss_next_addr got=%h exp=00000204", imemaddr); end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0; ihit = 1'b1;
    tick();
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rd_pre_count got=%0d exp=2", count); end
    redirect = 1'b1; redirect_pc = 32'h1003;
    tick();
    redirect = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rd_flush_count got=%0d exp=0", count); end
    checks++; if (imemaddr !== 32'h1000) begin errors++; $display("FAIL rd_target got=%h exp=00001000", imemaddr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got=%b exp=0", instr_valid); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_pc !== 32'h1000) begin errors++; $display("FAIL rd_first_pc got=%h exp=00001000", instr_pc); end
    // Second redirect lands on a cycle where a hit would otherwise be pushed.
    redirect = 1'b1; redirect_pc = 32'h2000;
    tick();
    redirect = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rd_discard_count got=%0d exp=0", count); end
    checks++; if (imemaddr !== 32'h2000) begin errors++; $display("FAIL rd_discard_addr got=%h exp=00002000", imemaddr); end
    tick();
    checks++; if (instr_pc !== 32'h2000) begin errors++; $display("FAIL rd_second_pc got=%h exp=00002000", instr_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rd_second_count got=%0d exp=1", count); end
  endtask

  task automatic test_wrap();
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; ihit = 1'b1; instr_ready = 1'b1;
    checks++; if (imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imemaddr); end
    tick();
    checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", instr_pc); end
    tick();
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got=%h exp=00000000", instr_pc); end
    checks++; if (instr !== word_of(32'h0)) begin errors++; $display("FAIL wrap_instr1 got=%h exp=%h", instr, word_of(32'h0)); end
    tick();
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL wrap_pc2 got=%h exp=00000004", instr_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    instr_ready = 1'b0; ihit = 1'b1;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL halt_pre_count got=%0d exp=1", count); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halt_ren got=%b exp=0", imemREN); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got=%b exp=0", instr_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL halt_count got=%0d exp=0", count); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL halt_instr got=%h exp=00000000", instr); end
    redirect = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL halted_ren[%0d] got=%b exp=0", i, imemREN); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halted_valid[%0d] got=%b exp=0", i, instr_valid); end
      checks++; if (imemaddr !== 32'h204) begin errors++; $display("FAIL halted_addr[%0d] got=%h exp=00000204", i, imemaddr); end
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++; if (imemaddr !== PC_INIT) begin errors++; $display("FAIL halt_rst_addr got=%h exp=%h", imemaddr, PC_INIT); end
    checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL halt_rst_ren got=%b exp=1", imemREN); end
    tick();
    checks++; if (instr_pc !== PC_INIT) begin errors++; $display("FAIL halt_rst_pc got=%h exp=%h", instr_pc, PC_INIT); end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  task automatic test_random();
    entry_t      q[$];
    logic [31:0] m_fpc;
    bit          m_halted;
    bit          m_ren, m_valid;
    logic [31:0] e_pc, e_ins;
    do_reset();
    m_fpc = PC_INIT; m_halted = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      RST         = ($urandom_range(0, 99) == 0);
      halt        = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom();
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      ihit        = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 1) != 0);
      #1;
      m_ren   = !m_halted && (q.size() < D) && !RST;
      m_valid = (q.size() != 0) && !m_halted && !RST;
      e_pc    = m_valid ? q[0].pc  : 32'h0;
      e_ins   = m_valid ? q[0].ins : 32'h0;
      checks++; if (imemREN !== m_ren) begin errors++; $display("FAIL rnd_ren[%0d] got=%b exp=%b", cyc, imemREN, m_ren); end
      checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, instr_valid, m_valid); end
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", cyc, count, q.size()); end
      checks++; if (imemaddr !== m_fpc) begin errors++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", cyc, imemaddr, m_fpc); end
      checks++; if (instr_pc !== e_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", cyc, instr_pc, e_pc); end
      checks++; if (instr !== e_ins) begin errors++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", cyc, instr, e_ins); end
      if (RST) begin
        q.delete(); m_fpc = PC_INIT; m_halted = 1'b0;
      end else if (!m_halted) begin
        if (halt) begin
          q.delete(); m_halted = 1'b1;
        end else if (redirect) begin
          q.delete(); m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
          if (m_valid && instr_ready) void'(q.pop_front());
          if (m_ren && ihit) begin
            q.push_back('{pc: m_fpc, ins: word_of(m_fpc)});
            m_fpc = m_fpc + 32'd4;
          end
        end
      end
      tick();
    end
    RST = 1'b0; halt = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_miss();
    test_redirect();
    test_wrap();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
